// File: rtl/sbus_spi_master.sv
// sbus_spi_master: mode-0 SPI master (MSB first, 8-bit frames) behind a system-bus register window
module sbus_spi_master #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] DIV_RESET = 8'd13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    input  logic       spi_miso,
    output logic       spi_mosi,
    output logic       spi_sclk,
    output logic       spi_cs_n
);
    typedef enum logic [1:0] {IDLE, LEAD, HIGH, LOW} state_t;
    state_t     state_q;
    logic [7:0] tx_q, rx_q, shift_q, div_q, hdiv_q, cnt_q, rdata_q;
    logic [7:0] off, rdata_d;
    logic [3:0] bits_q;
    logic       hold_q, rxv_q, ovr_q, ack_q, bus_q, sclk_q, mosi_q;
    logic       acc, wr, busy, tick;
    assign off      = addr - BASE_ADDR;
    // bus_q remembers an already-acked strobe so a held stb is never acked twice
    assign acc      = stb && (off < 8'd5) && !ack_q && !bus_q;
    assign wr       = acc && rw;
    assign busy     = state_q != IDLE;
    assign tick     = cnt_q == 8'd0;
    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = ~(busy | hold_q);
    always_comb
        rdata_d = (off == 8'd0) ? tx_q :
                  (off == 8'd1) ? rx_q :
                  (off == 8'd2) ? {5'b0, ovr_q, rxv_q, busy} :
                  (off == 8'd3) ? {7'b0, hold_q} : div_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            shift_q <= 8'h00;
            div_q   <= DIV_RESET;
            hdiv_q  <= DIV_RESET;
            cnt_q   <= 8'h00;
            rdata_q <= 8'h00;
            bits_q  <= 4'd0;
            hold_q  <= 1'b0;
            rxv_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            bus_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            bus_q   <= stb && (bus_q || acc);
            ack_q   <= acc;
            rdata_q <= (acc && !rw) ? rdata_d : 8'h00;
            if (acc && !rw && off == 8'd1) rxv_q <= 1'b0;
            if (wr && off == 8'd0 && busy) ovr_q <= 1'b1;
            if (wr && off == 8'd2 && wdata[2]) ovr_q <= 1'b0;
            if (wr && off == 8'd3) hold_q <= wdata[0];
            if (wr && off == 8'd4) div_q <= wdata;
            if (busy) cnt_q <= tick ? hdiv_q : cnt_q - 8'd1;
            case (state_q)
                IDLE: if (wr && off == 8'd0) begin
                    state_q <= LEAD;
                    tx_q    <= wdata;
                    shift_q <= wdata;
                    mosi_q  <= wdata[7];
                    hdiv_q  <= div_q;
                    cnt_q   <= div_q;
                    bits_q  <= 4'd0;
                end
                LEAD, LOW: if (tick) begin
                    if (state_q == LOW && bits_q == 4'd8) begin
                        state_q <= IDLE;
                        mosi_q  <= 1'b0;
                        rx_q    <= shift_q;
                        rxv_q   <= 1'b1;
                    end else begin
                        state_q <= HIGH;
                        sclk_q  <= 1'b1;
                        shift_q <= {shift_q[6:0], spi_miso};
                        bits_q  <= bits_q + 4'd1;
                    end
                end
                HIGH: if (tick) begin
                    state_q <= LOW;
                    sclk_q  <= 1'b0;
                    mosi_q  <= shift_q[7];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sbus_spi_master.sv
// tb_sbus_spi_master: directed register and SPI waveform checks for sbus_spi_master
module tb_sbus_spi_master;
    localparam logic [7:0] BASE = 8'h40;
    localparam logic [7:0] A_TX = BASE, A_RX = BASE + 8'd1, A_ST = BASE + 8'd2;
    localparam logic [7:0] A_CT = BASE + 8'd3, A_DV = BASE + 8'd4;
    logic       clk = 1'b0, rst, stb, rw, loop_en, miso_tie, watch, glitch;
    logic [7:0] addr, wdata, rdata;
    logic       ack, mosi, sclk, cs_n, miso;
    int         total, passed;
    assign miso = loop_en ? mosi : miso_tie;
    sbus_spi_master #(.BASE_ADDR(BASE), .DIV_RESET(8'd13)) dut (
        .clk(clk), .rst(rst), .stb(stb), .rw(rw), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .spi_miso(miso), .spi_mosi(mosi),
        .spi_sclk(sclk), .spi_cs_n(cs_n)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (watch && cs_n) glitch = 1'b1;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // stb is dropped for a full cycle before each access, then held until ack
    task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output logic got);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b1; rw = w; addr = a; wdata = d; got = 1'b0; rd = 8'h00;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        stb = 1'b0;
        if (!got) begin
            total++;
            $display("FAIL bus_timeout: addr %h got no ack, required ack", a);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic g;
        bus_xfer(1'b1, a, d, rd, g);
    endtask
    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        logic g;
        bus_xfer(1'b0, a, 8'h00, v, g);
    endtask
    task automatic measure(output int n, output int hi, output int pulses, output int lead,
                           output logic [7:0] seq);
        logic prev;
        n = 0; hi = 0; pulses = 0; lead = -1; seq = 8'h00; prev = 1'b0;
        while (!cs_n && n < 2000) begin
            if (sclk) begin
                hi++;
                if (!prev) begin
                    pulses++;
                    seq = {seq[6:0], mosi};
                    if (lead < 0) lead = n;
                end
            end
            prev = sclk;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b1; stb = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
        loop_en = 1'b0; miso_tie = 1'b0; watch = 1'b0; glitch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rdata); else passed++;
        total++; if ({sclk, mosi, cs_n} !== 3'b001) $display("FAIL rst_pins: sclk/mosi/cs_n got %b want 001", {sclk, mosi, cs_n}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        rd(A_ST, v);
        total++; if (v !== 8'h00) $display("FAIL rst_status: got %h want 00", v); else passed++;
        rd(A_DV, v);
        total++; if (v !== 8'd13) $display("FAIL rst_clkdiv: got %0d want 13", v); else passed++;
    endtask

    task automatic test_loopback;
        int n, hi, pulses, lead;
        logic [7:0] seq, v;
        wr(A_DV, 8'd0);
        loop_en = 1'b1;
        wr(A_TX, 8'hA5);
        measure(n, hi, pulses, lead, seq);
        total++; if (n !== 17) $display("FAIL lb_busy: got %0d cycles want 17", n); else passed++;
        total++; if (pulses !== 8) $display("FAIL lb_pulses: got %0d want 8", pulses); else passed++;
        total++; if (hi !== 8) $display("FAIL lb_high: got %0d high cycles want 8", hi); else passed++;
        total++; if (lead !== 1) $display("FAIL lb_lead: got %0d want 1", lead); else passed++;
        total++; if (seq !== 8'hA5) $display("FAIL lb_mosi: got %h want a5", seq); else passed++;
        total++; if ({sclk, mosi} !== 2'b00) $display("FAIL lb_idle_pins: got %b want 00", {sclk, mosi}); else passed++;
        rd(A_ST, v);
        total++; if (v !== 8'h02) $display("FAIL lb_status: got %h want 02", v); else passed++;
        rd(A_RX, v);
        total++; if (v !== 8'hA5) $display("FAIL lb_rxdata: got %h want a5", v); else passed++;
        rd(A_ST, v);
        total++; if (v !== 8'h00) $display("FAIL lb_status_clr: got %h want 00", v); else passed++;
        loop_en = 1'b0;
    endtask

    task automatic test_slow;
        int n, hi, pulses, lead;
        logic [7:0] seq, v;
        wr(A_DV, 8'd3);
        miso_tie = 1'b1;
        wr(A_TX, 8'h00);
        measure(n, hi, pulses, lead, seq);
        total++; if (n !== 68) $display("FAIL slow_busy: got %0d cycles want 68", n); else passed++;
        total++; if (hi !== 32) $display("FAIL slow_high: got %0d high cycles want 32", hi); else passed++;
        total++; if (pulses !== 8) $display("FAIL slow_pulses: got %0d want 8", pulses); else passed++;
        total++; if (lead !== 4) $display("FAIL slow_lead: got %0d want 4", lead); else passed++;
        total++; if (seq !== 8'h00) $display("FAIL slow_mosi: got %h want 00", seq); else passed++;
        rd(A_RX, v);
        total++; if (v !== 8'hFF) $display("FAIL slow_rxdata: got %h want ff", v); else passed++;
        miso_tie = 1'b0;
    endtask

    task automatic test_overrun;
        logic [7:0] v, rdv;
        logic g;
        int k;
        loop_en = 1'b1;
        wr(A_TX, 8'h3C);
        bus_xfer(1'b1, A_TX, 8'h11, rdv, g);
        total++; if (g !== 1'b1) $display("FAIL ovr_ack: got %b want 1", g); else passed++;
        rd(A_ST, v);
        total++; if (v !== 8'h05) $display("FAIL ovr_status_busy: got %h want 05", v); else passed++;
        rd(A_TX, v);
        total++; if (v !== 8'h3C) $display("FAIL ovr_txdata: got %h want 3c", v); else passed++;
        k = 0;
        while (!cs_n && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++; if (cs_n !== 1'b1) $display("FAIL ovr_done: cs_n got %b want 1", cs_n); else passed++;
        rd(A_ST, v);
        total++; if (v !== 8'h06) $display("FAIL ovr_status_done: got %h want 06", v); else passed++;
        wr(A_ST, 8'h07);
        rd(A_ST, v);
        total++; if (v !== 8'h02) $display("FAIL ovr_clear: got %h want 02", v); else passed++;
        rd(A_RX, v);
        total++; if (v !== 8'h3C) $display("FAIL ovr_rxdata: got %h want 3c", v); else passed++;
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] v, st;
        loop_en = 1'b1;
        wr(A_DV, 8'd0);
        wr(A_CT, 8'hFF);
        total++; if (cs_n !== 1'b0) $display("FAIL b2b_hold_cs: got %b want 0", cs_n); else passed++;
        glitch = 1'b0;
        watch = 1'b1;
        wr(A_TX, 8'h81);
        st = 8'h01;
        for (int k = 0; k < 40 && st[0]; k++) rd(A_ST, st);
        wr(A_TX, 8'h42);
        st = 8'h01;
        for (int k = 0; k < 40 && st[0]; k++) rd(A_ST, st);
        total++; if (st !== 8'h02) $display("FAIL b2b_status: got %h want 02", st); else passed++;
        total++; if (glitch !== 1'b0) $display("FAIL b2b_cs_glitch: got %b want 0", glitch); else passed++;
        total++; if (cs_n !== 1'b0) $display("FAIL b2b_cs_after: got %b want 0", cs_n); else passed++;
        watch = 1'b0;
        rd(A_RX, v);
        total++; if (v !== 8'h42) $display("FAIL b2b_rxdata: got %h want 42", v); else passed++;
        rd(A_CT, v);
        total++; if (v !== 8'h01) $display("FAIL b2b_ctrl: got %h want 01", v); else passed++;
        wr(A_CT, 8'h00);
        total++; if (cs_n !== 1'b1) $display("FAIL b2b_release: got %b want 1", cs_n); else passed++;
        loop_en = 1'b0;
    endtask

    task automatic test_bus;
        logic [7:0] v, ack_data;
        int acks, stray;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b1; rw = 1'b0; addr = A_RX;
        acks = 0; stray = 0; ack_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acks++;
                ack_data = rdata;
            end else if (rdata !== 8'h00) stray++;
        end
        stb = 1'b0;
        total++; if (acks !== 1) $display("FAIL bus_held_acks: got %0d want 1", acks); else passed++;
        total++; if (ack_data !== 8'h42) $display("FAIL bus_held_data: got %h want 42", ack_data); else passed++;
        total++; if (stray !== 0) $display("FAIL bus_rdata_idle: got %0d nonzero cycles want 0", stray); else passed++;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b1; rw = 1'b1; addr = BASE + 8'd5; wdata = 8'h77;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        stb = 1'b0;
        total++; if (acks !== 0) $display("FAIL bus_out_window: got %0d acks want 0", acks); else passed++;
        rd(A_DV, v);
        total++; if (v !== 8'h00) $display("FAIL bus_clkdiv_kept: got %h want 00", v); else passed++;
        rd(A_ST, v);
        total++; if (v !== 8'h00) $display("FAIL bus_status_kept: got %h want 00", v); else passed++;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] v;
        int k;
        wr(A_DV, 8'd2);
        wr(A_CT, 8'h01);
        wr(A_TX, 8'hFF);
        k = 0;
        while (!sclk && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++; if ({sclk, mosi, cs_n} !== 3'b110) $display("FAIL mid_pre: sclk/mosi/cs_n got %b want 110", {sclk, mosi, cs_n}); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if ({sclk, mosi, cs_n} !== 3'b001) $display("FAIL mid_async: sclk/mosi/cs_n got %b want 001", {sclk, mosi, cs_n}); else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(A_ST, v);
        total++; if (v !== 8'h00) $display("FAIL mid_status: got %h want 00", v); else passed++;
        rd(A_DV, v);
        total++; if (v !== 8'd13) $display("FAIL mid_clkdiv: got %0d want 13", v); else passed++;
        rd(A_CT, v);
        total++; if (v !== 8'h00) $display("FAIL mid_ctrl: got %h want 00", v); else passed++;
        rd(A_RX, v);
        total++; if (v !== 8'h00) $display("FAIL mid_rxdata: got %h want 00", v); else passed++;
        rd(A_TX, v);
        total++; if (v !== 8'h00) $display("FAIL mid_txdata: got %h want 00", v); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_loopback();
        test_slow();
        test_overrun();
        test_back_to_back();
        test_bus();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
